uc_fd: RTL and testbench
========================

# uc_fd

Multicycle control unit that drives the processor's fetch/datapath pair (PC_FD and FD). It latches each instruction the PC stage presents and sequences it through FETCH/DECODE/EXEC/MEM/WB. At each step it issues the PC controls (`inc`, `load`) and the datapath controls (Ra/Rb/Rw, WE_reg, WE_mem, OFFSET, OP_MEM, ADD_SUB). It supports an RV32I subset: add, sub, addi, lw, sw, beq.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  leaves IDLE on a one-cycle pulse
- instruction  in  32  instruction word from PC_FD
- zero  in  1  datapath flag, doutA == doutB, valid in EXEC
- inc  out  1  PC += 4 at the next clk edge
- load  out  1  PC += OFFSET at the next clk edge
- Ra, Rb, Rw  out  5 each  ir[19:15], ir[24:20], ir[11:7]
- WE_reg  out  1  register-bank write enable
- WE_mem  out  1  data-memory write enable
- OP_MEM  out  1  1 = write-back source is memory; 0 = ALU
- ALU_SRC  out  1  1 = ALU operand B is OFFSET; 0 = doutB
- ADD_SUB  out  1  1 = subtract
- OFFSET  out  32  sign-extended immediate
- busy  out  1  high in every state except IDLE and HALT
- halt  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset state is IDLE, and every output is 0 at reset:
  - the internal `ir` and `retired` are cleared;
  - Ra/Rb/Rw/OFFSET are therefore 0.
- IDLE → FETCH when start=1. start is ignored in every other state.
- FETCH: `ir` <= instruction at the edge. Go to DECODE.
- DECODE: classify `ir[6:0]`.
  - 0110011 with funct7 ∈ {0000000, 0100000} and funct3 = 000 → R-type.
  - 0010011 with funct3 = 000 → addi.
  - 0000011 with funct3 = 010 → lw.
  - 0100011 with funct3 = 010 → sw.
  - 1100011 with funct3 = 000 → beq.
  - Anything else → HALT.
- EXEC:
  - ADD_SUB = 1 for sub and for beq; otherwise 0.
  - ALU_SRC = 1 for addi, lw and sw.
  - beq: if zero=1, assert load and go to FETCH; if zero=0, assert inc and go to FETCH.
  - R-type and addi go to WB.
  - lw and sw go to MEM.
- MEM:
  - sw: WE_mem = 1, inc = 1, next state FETCH.
  - lw: no write; next state WB.
- WB:
  - WE_reg = 1 unless Rw == 0, so x0 is never written.
  - OP_MEM = 1 for lw.
  - inc = 1, next state FETCH.
- OFFSET, formed combinationally from `ir`:
  - I-type: sext(ir[31:20]).
  - S-type: sext({ir[31:25], ir[11:7]}).
  - B-type: sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}).
  - R-type: 0.
- retired increments by 1 in every cycle where inc or load is asserted. It wraps from 2^CNT_W−1 to 0.
- HALT: halt = 1 and all enables stay 0. HALT is left only by reset; start is ignored.

## Timing
- All control outputs are Moore-style: a function of state and `ir` only, except beq load/inc, which also depends on `zero`.
- Cycles per instruction:
  - beq: 3
  - add/sub/addi: 4
  - sw: 4
  - lw: 5
- inc and load are mutually exclusive. Each is asserted for exactly one cycle per retired instruction.
- WE_reg and WE_mem never assert in the same cycle, and never in FETCH or DECODE.
- `ir` is stable from the cycle after FETCH until the next FETCH edge. Ra/Rb/Rw/OFFSET are therefore valid from DECODE onward.
- Reset asserted mid-instruction: state goes to IDLE immediately (asynchronously) and no partial write is issued afterwards.
- start arriving in the same cycle reset deasserts is ignored.

## Structure
- Package `uc_fd_pkg` holds:
  - the state enum;
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - the funct7 constant for sub.
- Sub-module `imm_gen_fd`: combinational 32→32 immediate generator, selected by opcode.
- The FSM, `ir` and the counter live in `uc_fd`.

## Test plan
- After reset, start; instruction 0x002081B3 (add x3,x1,x2):
  - states go FETCH, DECODE, EXEC, WB;
  - in WB, WE_reg=1, Rw=3, ADD_SUB=0 and inc=1;
  - retired=1.
- 0x402081B3 (sub) → ADD_SUB=1 in EXEC. 0xFFF00093 (addi x1,x0,-1) → OFFSET=0xFFFFFFFF and ALU_SRC=1.
- 0x00802283 (lw x5,8(x0)):
  - 5 cycles in total; OFFSET=8;
  - in WB, OP_MEM=1 and WE_reg=1.
- 0x00502623 (sw x5,12(x0)) → OFFSET=12, WE_mem=1 only in MEM, WE_reg never asserted.
- 0xFE000CE3 (beq x0,x0,-8):
  - with zero=1: load=1 in EXEC, OFFSET=0xFFFFFFF8, inc=0;
  - with zero=0: inc=1 instead.
- 0x00000000 → HALT with halt=1. Further start pulses are ignored. Reset mid-lw, before WB, → no WE_reg pulse and all outputs 0.

Source files
------------

// File: rtl/uc_fd_pkg.sv
// Shared types and encodings for the uc_fd multicycle control unit.
package uc_fd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Decoded instruction class, captured once in DECODE.
    typedef enum logic [2:0] {
        I_ILL,
        I_ADD,
        I_SUB,
        I_ADDI,
        I_LW,
        I_SW,
        I_BEQ
    } instr_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // Map opcode/funct fields onto the supported subset; anything else is illegal.
    function automatic instr_t classify(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
        instr_t c;
        c = I_ILL;
        case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7 == F7_ADD) c = I_ADD;
                else if (funct3 == 3'b000 && funct7 == F7_SUB) c = I_SUB;
            end
            OP_IMM:    if (funct3 == 3'b000) c = I_ADDI;
            OP_LOAD:   if (funct3 == 3'b010) c = I_LW;
            OP_STORE:  if (funct3 == 3'b010) c = I_SW;
            OP_BRANCH: if (funct3 == 3'b000) c = I_BEQ;
            default:   c = I_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen_fd.sv
// Combinational immediate generator: sign-extended I/S/B immediates, 0 otherwise.
module imm_gen_fd
    import uc_fd_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    // funct3 and rs1 never contribute to an I/S/B immediate.
    logic [7:0] unused_bits;
    assign unused_bits = ir[19:12];

    // Immediate format is chosen purely by opcode.
    always_comb begin
        imm = '0;
        case (ir[6:0])
            OP_IMM, OP_LOAD: imm = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH:       imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:         imm = '0;
        endcase
    end

endmodule

// File: rtl/uc_fd.sv
// Multicycle control unit for the PC_FD / FD fetch-datapath pair.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// FETCH  | ir captures the instruction at the closing edge
// DECODE | classify ir, select next step or HALT
// EXEC   | ALU operation; beq resolves here using zero
// MEM    | sw writes memory; lw waits for read data
// WB     | register write-back, PC += 4
// HALT   | illegal opcode seen; only reset leaves
module uc_fd
    import uc_fd_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      instruction,
    input  logic             zero,
    output logic             inc,
    output logic             load,
    output logic [4:0]       Ra,
    output logic [4:0]       Rb,
    output logic [4:0]       Rw,
    output logic             WE_reg,
    output logic             WE_mem,
    output logic             OP_MEM,
    output logic             ALU_SRC,
    output logic             ADD_SUB,
    output logic [31:0]      OFFSET,
    output logic             busy,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    state_t      state;
    instr_t      cls;
    instr_t      dec;
    logic [31:0] ir;
    logic        armed;
    logic        inc_q;
    logic        beq_exec;
    logic        rw_nz;

    assign Ra    = ir[19:15];
    assign Rb    = ir[24:20];
    assign Rw    = ir[11:7];
    assign rw_nz = (ir[11:7] != 5'd0);
    assign dec   = classify(ir[6:0], ir[14:12], ir[31:25]);

    imm_gen_fd u_imm (
        .ir  (ir),
        .imm (OFFSET)
    );

    // beq is the only Mealy path: the branch decision needs the live zero flag.
    assign beq_exec = (state == S_EXEC) && (cls == I_BEQ);
    assign load     = beq_exec && zero;
    assign inc      = inc_q || (beq_exec && !zero);
    assign busy     = (state != S_IDLE) && (state != S_HALT);

    // Sequencer: outputs for the next state are registered on the transition into it.
    // ALU_SRC/ADD_SUB stay held from EXEC through WB so the ALU result and memory
    // address remain stable while they are consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cls     <= I_ILL;
            ir      <= '0;
            armed   <= 1'b0;
            retired <= '0;
            inc_q   <= 1'b0;
            WE_reg  <= 1'b0;
            WE_mem  <= 1'b0;
            OP_MEM  <= 1'b0;
            ALU_SRC <= 1'b0;
            ADD_SUB <= 1'b0;
            halt    <= 1'b0;
        end else begin
            // armed keeps a start coincident with reset release from being taken.
            armed  <= 1'b1;
            inc_q  <= 1'b0;
            WE_reg <= 1'b0;
            WE_mem <= 1'b0;
            OP_MEM <= 1'b0;
            if (inc || load) retired <= retired + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (start && armed) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    cls <= dec;
                    if (dec == I_ILL) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                    end else begin
                        state   <= S_EXEC;
                        ADD_SUB <= (dec == I_SUB) || (dec == I_BEQ);
                        ALU_SRC <= (dec == I_ADDI) || (dec == I_LW) || (dec == I_SW);
                    end
                end
                S_EXEC: begin
                    case (cls)
                        I_ADD, I_SUB, I_ADDI: begin
                            state  <= S_WB;
                            WE_reg <= rw_nz;
                            inc_q  <= 1'b1;
                        end
                        I_LW: state <= S_MEM;
                        I_SW: begin
                            state  <= S_MEM;
                            WE_mem <= 1'b1;
                            inc_q  <= 1'b1;
                        end
                        default: begin
                            state   <= S_FETCH;
                            ADD_SUB <= 1'b0;
                            ALU_SRC <= 1'b0;
                        end
                    endcase
                end
                S_MEM: begin
                    if (cls == I_LW) begin
                        state  <= S_WB;
                        WE_reg <= rw_nz;
                        OP_MEM <= 1'b1;
                        inc_q  <= 1'b1;
                    end else begin
                        state   <= S_FETCH;
                        ADD_SUB <= 1'b0;
                        ALU_SRC <= 1'b0;
                    end
                end
                S_WB: begin
                    state   <= S_FETCH;
                    ADD_SUB <= 1'b0;
                    ALU_SRC <= 1'b0;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_fd.sv
// Directed bench for uc_fd: walks add/sub/addi/lw/sw/beq/illegal and mid-instruction reset.
module tb_uc_fd;
    import uc_fd_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic        zero;
    logic        inc, load, WE_reg, WE_mem, OP_MEM, ALU_SRC, ADD_SUB, busy, halt;
    logic [4:0]  Ra, Rb, Rw;
    logic [31:0] OFFSET;
    logic [15:0] retired;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADD_W  = 32'h002081B3;
    localparam logic [31:0] I_SUB_W  = 32'h402081B3;
    localparam logic [31:0] I_ADDI_W = 32'hFFF00093;
    localparam logic [31:0] I_LW_W   = 32'h00802283;
    localparam logic [31:0] I_SW_W   = 32'h00502623;
    localparam logic [31:0] I_BEQ_W  = 32'hFE000CE3;

    // ctrl = {inc, load, WE_reg, WE_mem, OP_MEM, ALU_SRC, ADD_SUB, busy, halt}
    localparam logic [8:0] C_IDLE    = 9'b000000000;
    localparam logic [8:0] C_BUSY    = 9'b000000010;
    localparam logic [8:0] C_ADD_EX  = 9'b000000010;
    localparam logic [8:0] C_ADD_WB  = 9'b101000010;
    localparam logic [8:0] C_SUB_EX  = 9'b000000110;
    localparam logic [8:0] C_SUB_WB  = 9'b101000110;
    localparam logic [8:0] C_IMM_EX  = 9'b000001010;
    localparam logic [8:0] C_ADDI_WB = 9'b101001010;
    localparam logic [8:0] C_LW_WB   = 9'b101011010;
    localparam logic [8:0] C_SW_MEM  = 9'b100101010;
    localparam logic [8:0] C_BEQ_T   = 9'b010000110;
    localparam logic [8:0] C_BEQ_N   = 9'b100000110;
    localparam logic [8:0] C_HALT    = 9'b000000001;

    logic [8:0] ctrl;
    assign ctrl = {inc, load, WE_reg, WE_mem, OP_MEM, ALU_SRC, ADD_SUB, busy, halt};

    uc_fd #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .zero        (zero),
        .inc         (inc),
        .load        (load),
        .Ra          (Ra),
        .Rb          (Rb),
        .Rw          (Rw),
        .WE_reg      (WE_reg),
        .WE_mem      (WE_mem),
        .OP_MEM      (OP_MEM),
        .ALU_SRC     (ALU_SRC),
        .ADD_SUB     (ADD_SUB),
        .OFFSET      (OFFSET),
        .busy        (busy),
        .halt        (halt),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [8:0] exp);
        chk(tag, {23'b0, ctrl}, {23'b0, exp});
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk(tag, {29'b0, dut.state}, {29'b0, exp});
    endtask

    task automatic chk_ret(input string tag, input logic [15:0] exp);
        chk(tag, {16'b0, retired}, {16'b0, exp});
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; instruction = 32'h0; zero = 1'b0;
        tick; tick;
        chk_state("rst_state", S_IDLE);
        chk_ctrl("rst_ctrl", C_IDLE);
        chk("rst_rw", {27'b0, Rw}, 32'd0);
        chk("rst_offset", OFFSET, 32'd0);
        chk_ret("rst_retired", 16'd0);

        // start coincident with reset release is ignored
        reset = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk_state("start_at_release_ignored", S_IDLE);

        // add x3,x1,x2
        start = 1'b1; instruction = I_ADD_W;
        tick; start = 1'b0;
        chk_state("add_fetch", S_FETCH);   chk_ctrl("add_fetch_ctrl", C_BUSY);
        tick;
        chk_state("add_decode", S_DECODE); chk_ctrl("add_decode_ctrl", C_BUSY);
        chk("add_ra", {27'b0, Ra}, 32'd1);
        chk("add_rb", {27'b0, Rb}, 32'd2);
        chk("add_rw", {27'b0, Rw}, 32'd3);
        chk("add_offset", OFFSET, 32'd0);
        tick;
        chk_state("add_exec", S_EXEC);     chk_ctrl("add_exec_ctrl", C_ADD_EX);
        tick;
        chk_state("add_wb", S_WB);         chk_ctrl("add_wb_ctrl", C_ADD_WB);
        chk_ret("add_ret_before", 16'd0);
        instruction = I_SUB_W;

        // sub x3,x1,x2
        tick;
        chk_state("sub_fetch", S_FETCH);   chk_ret("add_retired", 16'd1);
        tick; tick;
        chk_state("sub_exec", S_EXEC);     chk_ctrl("sub_exec_ctrl", C_SUB_EX);
        tick;
        chk_ctrl("sub_wb_ctrl", C_SUB_WB);
        instruction = I_ADDI_W;

        // addi x1,x0,-1
        tick;
        chk_ret("sub_retired", 16'd2);
        tick;
        chk("addi_offset", OFFSET, 32'hFFFFFFFF);
        chk("addi_rw", {27'b0, Rw}, 32'd1);
        tick;
        chk_ctrl("addi_exec_ctrl", C_IMM_EX);
        tick;
        chk_ctrl("addi_wb_ctrl", C_ADDI_WB);
        instruction = I_LW_W;

        // lw x5,8(x0): FETCH DECODE EXEC MEM WB
        tick;
        chk_state("lw_fetch", S_FETCH);    chk_ret("addi_retired", 16'd3);
        tick;
        chk("lw_offset", OFFSET, 32'd8);
        chk("lw_rw", {27'b0, Rw}, 32'd5);
        chk_ctrl("lw_decode_ctrl", C_BUSY);
        tick;
        chk_state("lw_exec", S_EXEC);      chk_ctrl("lw_exec_ctrl", C_IMM_EX);
        tick;
        chk_state("lw_mem", S_MEM);        chk_ctrl("lw_mem_ctrl", C_IMM_EX);
        tick;
        chk_state("lw_wb", S_WB);          chk_ctrl("lw_wb_ctrl", C_LW_WB);
        chk_ret("lw_ret_before", 16'd3);
        instruction = I_SW_W;

        // sw x5,12(x0): FETCH DECODE EXEC MEM
        tick;
        chk_state("sw_fetch", S_FETCH);    chk_ret("lw_retired", 16'd4);
        tick;
        chk("sw_offset", OFFSET, 32'd12);
        chk("sw_rb", {27'b0, Rb}, 32'd5);
        chk_ctrl("sw_decode_ctrl", C_BUSY);
        tick;
        chk_ctrl("sw_exec_ctrl", C_IMM_EX);
        tick;
        chk_state("sw_mem", S_MEM);        chk_ctrl("sw_mem_ctrl", C_SW_MEM);
        instruction = I_BEQ_W; zero = 1'b1;

        // beq x0,x0,-8 taken
        tick;
        chk_state("beq_t_fetch", S_FETCH); chk_ret("sw_retired", 16'd5);
        chk_ctrl("beq_t_fetch_ctrl", C_BUSY);
        tick;
        chk("beq_offset", OFFSET, 32'hFFFFFFF8);
        tick;
        chk_state("beq_t_exec", S_EXEC);   chk_ctrl("beq_t_exec_ctrl", C_BEQ_T);

        // beq not taken
        tick;
        chk_state("beq_n_fetch", S_FETCH); chk_ret("beq_t_retired", 16'd6);
        zero = 1'b0;
        tick; tick;
        chk_state("beq_n_exec", S_EXEC);   chk_ctrl("beq_n_exec_ctrl", C_BEQ_N);
        instruction = 32'h00000000;

        // illegal opcode -> HALT
        tick;
        chk_ret("beq_n_retired", 16'd7);
        tick; tick;
        chk_state("halt_state", S_HALT);   chk_ctrl("halt_ctrl", C_HALT);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk_state("halt_ignores_start", S_HALT);
        chk_ctrl("halt_ctrl_sticky", C_HALT);
        chk_ret("halt_retired", 16'd7);

        // reset clears HALT
        reset = 1'b0;
        #1;
        chk_state("halt_reset_state", S_IDLE);
        chk_ctrl("halt_reset_ctrl", C_IDLE);
        chk_ret("halt_reset_retired", 16'd0);
        tick;
        reset = 1'b1;
        tick;

        // reset mid-lw, in EXEC
        start = 1'b1; instruction = I_LW_W;
        tick; start = 1'b0;
        chk_state("lw2_fetch", S_FETCH);
        tick; tick;
        chk_state("lw2_exec", S_EXEC);
        #1 reset = 1'b0;
        #1;
        chk_state("midlw_reset_state", S_IDLE);
        chk_ctrl("midlw_reset_ctrl", C_IDLE);
        chk("midlw_reset_rw", {27'b0, Rw}, 32'd0);
        chk("midlw_reset_offset", OFFSET, 32'd0);
        tick; tick;
        reset = 1'b1;
        tick;
        chk_ctrl("after_reset_ctrl_1", C_IDLE);
        tick;
        chk_ctrl("after_reset_ctrl_2", C_IDLE);
        chk_state("after_reset_state", S_IDLE);
        chk_ret("after_reset_retired", 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
